// File: rtl/mul_pkg.sv
// Shared types and elaboration helpers for the iterative multiplier.
package mul_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  function automatic int step_count(input int width, input int bpc);
    return width / bpc;
  endfunction

  function automatic bit params_legal(input int width, input int bpc);
    return (width >= 4) && ((width % 2) == 0) &&
           ((bpc == 1) || (bpc == 2) || (bpc == 4)) && ((width % bpc) == 0);
  endfunction

endpackage

// File: rtl/mul_step.sv
// One radix-2^BPC iteration: adds |x| times a BPC-bit multiplier slice, shifted into place.
module mul_step
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 2,
  parameter int SW    = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0]   xmag,
  input  logic [BPC-1:0]     yslice,
  input  logic [SW-1:0]      shamt,
  input  logic [2*WIDTH-1:0] prod_in,
  output logic [2*WIDTH-1:0] prod_out
);

  logic [2*WIDTH-1:0] pp;

  assign pp       = {{WIDTH{1'b0}}, xmag} * {{(2*WIDTH-BPC){1'b0}}, yslice};
  assign prod_out = prod_in + (pp << shamt);

endmodule

// File: rtl/mul_iter.sv
// Iterative signed/unsigned WIDTH x WIDTH multiplier with valid/ready handshakes and cancel.
// Optional feature: define MUL_EARLY_OUT_EN to finish as soon as the remaining multiplier is zero.
module mul_iter
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 2
) (
  input  logic               mul_clk,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               cancel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int N  = step_count(WIDTH, BPC);
  localparam int CW = $clog2(N + 1);
  localparam int SW = $clog2(2 * WIDTH);

  if (!params_legal(WIDTH, BPC)) begin : g_bad_params
    $error("mul_iter: illegal WIDTH/BPC combination");
  end

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   xmag_q;
  logic [WIDTH-1:0]   yrem_q;
  logic [WIDTH-1:0]   yrem_d;
  logic               neg_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_d;
  logic [2*WIDTH-1:0] result_q;
  logic               out_valid_q;
  logic [SW-1:0]      shamt;
  logic               accept;
  logic               last_step;

  assign in_ready  = !cancel && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

  assign yrem_d = yrem_q >> BPC;
  assign shamt  = SW'((N - int'(cnt_q)) * BPC);

`ifdef MUL_EARLY_OUT_EN
  assign last_step = (cnt_q == CW'(1)) || (yrem_d == '0);
`else
  assign last_step = (cnt_q == CW'(1));
`endif

  mul_step #(
    .WIDTH (WIDTH),
    .BPC   (BPC),
    .SW    (SW)
  ) u_step (
    .xmag     (xmag_q),
    .yslice   (yrem_q[BPC-1:0]),
    .shamt    (shamt),
    .prod_in  (prod_q),
    .prod_out (prod_d)
  );

  // Control and registered outputs; cancel overrides every transition.
  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else if (cancel) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= CALC;
            cnt_q   <= CW'(N);
          end
        end
        CALC: begin
          cnt_q <= cnt_q - CW'(1);
          if (last_step) state_q <= FIX;
        end
        FIX: begin
          result_q    <= neg_q ? -prod_q : prod_q;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (accept) begin
              state_q <= CALC;
              cnt_q   <= CW'(N);
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Operand and accumulator registers need no reset: they are reloaded on every accept.
  always_ff @(posedge mul_clk) begin
    if (accept) begin
      xmag_q <= magnitude(x, in_signed);
      yrem_q <= magnitude(y, in_signed);
      neg_q  <= in_signed && (x[WIDTH-1] ^ y[WIDTH-1]);
      prod_q <= '0;
    end else if (state_q == CALC) begin
      prod_q <= prod_d;
      yrem_q <= yrem_d;
    end
  end

endmodule
